apb_mst_bridge: RTL and testbench
=================================

APB_MST_BRIDGE -- requirements
Module: apb_mst_bridge

Interface
REQ-001 SHALL have parameter P_ADDR_BITWIDTH, default 32, APB address width.
REQ-002 SHALL have parameter P_DATA_BITWIDTH, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter P_TIMEOUT_CYCLES, default 256, wait-state limit (used only with APB_MST_TIMEOUT_EN).
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports in this order:
- PCLK  in  1  clock
- PRESETn  in  1  async active-low reset
- cmd_valid  in  1  request valid
- cmd_ready  out  1  request accepted
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  P_ADDR_BITWIDTH  target address
- cmd_wdata  in  P_DATA_BITWIDTH  write data
- cmd_strb  in  P_DATA_BITWIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  P_DATA_BITWIDTH  read data
- rsp_err  out  1  slave error or timeout
- PADDR  out  P_ADDR_BITWIDTH  APB address
- PPROT  out  3  APB protection
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  P_DATA_BITWIDTH  APB write data
- PSTRB  out  P_DATA_BITWIDTH/8  APB strobes
- PREADY  in  1  APB ready
- PRDATA  in  P_DATA_BITWIDTH  APB read data
- PSLVERR  in  1  APB error

Function
REQ-005 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at most.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready, latch all cmd_* fields and go to SETUP.
REQ-007 In SETUP, SHALL drive PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB/PPROT from latched fields; next state ACCESS unconditionally.
REQ-008 In ACCESS, SHALL drive PSEL=1, PENABLE=1, with all APB address/control/data held stable until PREADY=1 is sampled.
REQ-009 On PREADY=1 in ACCESS, SHALL capture rsp_rdata=PRDATA for reads (0 for writes), rsp_err=PSLVERR, go to RESP.
REQ-010 In RESP, SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then go to IDLE.
REQ-011 SHALL drive PSTRB=0 for reads.
REQ-012 SHALL drive PSEL=0 and PENABLE=0 in IDLE and RESP; PADDR/PWDATA hold their last values.
REQ-013 Minimum latency with zero wait states: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid at N+3.
REQ-014 PREADY, PRDATA and PSLVERR SHALL be ignored outside ACCESS.
REQ-015 cmd_valid in any state other than IDLE SHALL NOT be accepted and SHALL NOT alter the in-flight transfer.

Reset
REQ-016 While PRESETn=0, SHALL force state IDLE and every output to 0, including cmd_ready.
REQ-017 Reset asserted during SETUP, ACCESS or RESP SHALL deassert PSEL/PENABLE immediately and discard the transfer and its response.

Configuration
REQ-018 With macro APB_MST_TIMEOUT_EN defined, SHALL count ACCESS cycles with PREADY=0; on reaching P_TIMEOUT_CYCLES it SHALL end the transfer (PSEL=PENABLE=0 next cycle), set rsp_err=1, rsp_rdata=0, and enter RESP.
REQ-019 The timeout counter SHALL clear on entry to SETUP.
REQ-020 Without APB_MST_TIMEOUT_EN, SHALL wait indefinitely for PREADY, and the counter logic SHALL be absent.

Verification
REQ-021 Write, cmd_addr=0x08, cmd_wdata=0x1234, cmd_strb=0xF, PREADY=1 -> PSEL cycle N+1, PENABLE N+2, PSTRB=0xF, rsp_valid N+3, rsp_err=0.
REQ-022 Read, cmd_addr=0x10, PRDATA=0xDEADBEEF, 3 wait states -> PADDR stable 5 cycles, PSTRB=0, rsp_rdata=0xDEADBEEF at N+6.
REQ-023 Write with PSLVERR=1 on completion -> rsp_err=1; rsp_valid held 4 cycles while rsp_ready=0, then IDLE with cmd_ready=1.
REQ-024 Back-to-back cmd_valid held high -> second request accepted only after RESP handshake; no overlap of PSEL between transfers.
REQ-025 PRESETn pulsed low during ACCESS -> PSEL/PENABLE/rsp_valid 0 immediately; cmd_ready=1 on first clock after release.
REQ-026 APB_MST_TIMEOUT_EN defined, P_TIMEOUT_CYCLES=4, PREADY stuck 0 -> rsp_err=1, rsp_rdata=0 after 4 ACCESS cycles; undefined -> PENABLE stays 1 for at least 100 cycles.

Source files
------------

// File: rtl/apb_mst_bridge.sv
`timescale 1ns/1ps
// Command/response to APB master bridge: one transfer in flight, registered APB outputs.
// Optional wait-state timeout is compiled in with the APB_MST_TIMEOUT_EN macro.
module apb_mst_bridge #(
    parameter int P_ADDR_BITWIDTH  = 32,
    parameter int P_DATA_BITWIDTH  = 32,
    parameter int P_TIMEOUT_CYCLES = 256
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [P_ADDR_BITWIDTH-1:0]   cmd_addr,
    input  logic [P_DATA_BITWIDTH-1:0]   cmd_wdata,
    input  logic [P_DATA_BITWIDTH/8-1:0] cmd_strb,
    input  logic [2:0]                   cmd_prot,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [P_DATA_BITWIDTH-1:0]   rsp_rdata,
    output logic                         rsp_err,
    output logic [P_ADDR_BITWIDTH-1:0]   PADDR,
    output logic [2:0]                   PPROT,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [P_DATA_BITWIDTH-1:0]   PWDATA,
    output logic [P_DATA_BITWIDTH/8-1:0] PSTRB,
    input  logic                         PREADY,
    input  logic [P_DATA_BITWIDTH-1:0]   PRDATA,
    input  logic                         PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state;

`ifdef APB_MST_TIMEOUT_EN
    localparam int CW = $clog2(P_TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;
`endif

    // cmd_ready is registered: it rises on the clock that enters IDLE and
    // falls on the clock that accepts a command, so it is 1 exactly in IDLE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PADDR     <= '0;
            PPROT     <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
`ifdef APB_MST_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        PADDR     <= cmd_addr;
                        PPROT     <= cmd_prot;
                        PWRITE    <= cmd_write;
                        PWDATA    <= cmd_wdata;
                        PSTRB     <= cmd_write ? cmd_strb : '0;
                        PSEL      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= S_SETUP;
`ifdef APB_MST_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        state     <= S_RESP;
                    end
`ifdef APB_MST_TIMEOUT_EN
                    // Abandon a slave that never answers; the response reports an error.
                    else if (to_cnt == CW'(P_TIMEOUT_CYCLES - 1)) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_mst_bridge.sv
`timescale 1ns/1ps
// Self-checking bench for apb_mst_bridge: directed scenarios plus a random
// mix, responses checked against a scoreboard of {err, rdata} entries.
module tb_apb_mst_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] PADDR;
    logic [2:0]    PPROT;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic          PSLVERR = 1'b0;

    int compared = 0;
    int mismatched = 0;
    logic [DW:0] exp_q[$];

    apb_mst_bridge #(
        .P_ADDR_BITWIDTH (AW),
        .P_DATA_BITWIDTH (DW),
        .P_TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_strb (cmd_strb),
        .cmd_prot (cmd_prot),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PADDR    (PADDR),
        .PPROT    (PPROT),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR)
    );

    // clock / watchdog
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    // Driver: called at a negedge in IDLE; returns at the SETUP negedge.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [2:0] p,
                            input logic exp_err, input logic [DW-1:0] exp_rd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        exp_q.push_back({exp_err, exp_rd});
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL send_cmd_ready: got %b want 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Scoreboard consumer: waits (bounded) for rsp_valid, compares, handshakes.
    task automatic collect_rsp(input string tag, input int budget);
        logic [DW:0] exp;
        int n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_rsp_timeout: rsp_valid=%b after %0d cycles, want 1", tag, rsp_valid, budget);
        end else if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s_rsp_unexpected: got err=%b rdata=%h, want no response", tag, rsp_err, rsp_rdata);
        end else begin
            exp = exp_q.pop_front();
            if ({rsp_err, rsp_rdata} !== exp) begin
                mismatched++;
                $display("FAIL %s_rsp: got err=%b rdata=%h want err=%b rdata=%h",
                         tag, rsp_err, rsp_rdata, exp[DW], exp[DW-1:0]);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_rdata, PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: cmd_ready=%b rsp_valid=%b PSEL=%b PENABLE=%b PADDR=%h want all 0",
                     cmd_ready, rsp_valid, PSEL, PENABLE, PADDR);
        end
        tick();
        PRESETn = 1'b1;
        tick();
        compared++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: cmd_ready=%b PSEL=%b want 1 0", cmd_ready, PSEL);
        end
    endtask

    task automatic test_write();
        PREADY = 1'b1;
        PRDATA = 32'hCAFE_0000;
        send_cmd(1'b1, 32'h08, 32'h1234, 4'hF, 3'b010, 1'b0, '0);
        compared++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== {3'b101, 32'h08, 32'h1234, 4'hF, 3'b010}) begin
            mismatched++;
            $display("FAIL write_setup: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h PSTRB=%h PPROT=%b want 1 0 1 08 1234 f 010",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT);
        end
        tick();
        compared++;
        if ({PSEL, PENABLE, cmd_ready} !== 3'b110) begin
            mismatched++;
            $display("FAIL write_access: PSEL=%b PENABLE=%b cmd_ready=%b want 1 1 0", PSEL, PENABLE, cmd_ready);
        end
        tick();
        compared++;
        if ({rsp_valid, PSEL, PENABLE} !== 3'b100) begin
            mismatched++;
            $display("FAIL write_resp_latency: rsp_valid=%b PSEL=%b PENABLE=%b want 1 0 0", rsp_valid, PSEL, PENABLE);
        end
        collect_rsp("write", 1);
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL write_idle: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_read_wait();
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        PRDATA  = 32'h0BAD_F00D;
        send_cmd(1'b0, 32'h10, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0, 32'hDEAD_BEEF);
        for (int c = 1; c <= 5; c++) begin
            compared++;
            if ({PSEL, PENABLE, PADDR, PSTRB, PWRITE} !== {1'b1, c >= 2, 32'h10, 4'h0, 1'b0}) begin
                mismatched++;
                $display("FAIL read_hold_c%0d: PSEL=%b PENABLE=%b PADDR=%h PSTRB=%h PWRITE=%b want 1 %b 10 0 0",
                         c, PSEL, PENABLE, PADDR, PSTRB, PWRITE, c >= 2);
            end
            if (c == 3) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = 32'h99;
                compared++;
                if (cmd_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL read_busy_ready: cmd_ready=%b want 0", cmd_ready);
                end
            end
            if (c == 4) cmd_valid = 1'b0;
            if (c == 5) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b0;
                PRDATA  = 32'hDEAD_BEEF;
            end
            tick();
        end
        compared++;
        if (rsp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL read_resp_latency: rsp_valid=%b want 1 at N+6", rsp_valid);
        end
        PRDATA = 32'h1111_1111;
        collect_rsp("read", 1);
    endtask

    task automatic test_slverr();
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        send_cmd(1'b1, 32'h20, 32'h55AA, 4'b0011, 3'b001, 1'b1, '0);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            compared++;
            if ({rsp_valid, rsp_err, cmd_ready} !== 3'b110) begin
                mismatched++;
                $display("FAIL slverr_hold_%0d: rsp_valid=%b rsp_err=%b cmd_ready=%b want 1 1 0",
                         i, rsp_valid, rsp_err, cmd_ready);
            end
            PSLVERR = 1'b0;
            tick();
        end
        collect_rsp("slverr", 1);
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL slverr_idle: cmd_ready=%b want 1", cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_psel[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic exp_rdy[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [AW-1:0] exp_addr[7] = '{32'h30, 32'h30, 32'h0, 32'h0, 32'h40, 32'h40, 32'h0};
        logic [DW:0] exp;
        int seen = 0;
        PREADY    = 1'b1;
        PRDATA    = 32'h1234_5678;
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h30;
        cmd_wdata = 32'h1;
        cmd_strb  = 4'h1;
        exp_q.push_back({1'b0, 32'h0});
        tick();
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        exp_q.push_back({1'b0, 32'h1234_5678});
        for (int c = 0; c < 7; c++) begin
            compared++;
            if (PSEL !== exp_psel[c] || cmd_ready !== exp_rdy[c] || (exp_psel[c] && PADDR !== exp_addr[c])) begin
                mismatched++;
                $display("FAIL b2b_c%0d: PSEL=%b cmd_ready=%b PADDR=%h want %b %b %h",
                         c, PSEL, cmd_ready, PADDR, exp_psel[c], exp_rdy[c], exp_addr[c]);
            end
            if (rsp_valid === 1'b1) begin
                seen++;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                compared++;
                if ({rsp_err, rsp_rdata} !== exp) begin
                    mismatched++;
                    $display("FAIL b2b_rsp%0d: got err=%b rdata=%h want err=%b rdata=%h",
                             seen, rsp_err, rsp_rdata, exp[DW], exp[DW-1:0]);
                end
            end
            if (c == 4) cmd_valid = 1'b0;
            tick();
        end
        rsp_ready = 1'b0;
        compared++;
        if (seen != 2) begin
            mismatched++;
            $display("FAIL b2b_rsp_count: got %0d responses want 2", seen);
        end
    endtask

    task automatic test_reset_access();
        PREADY = 1'b0;
        send_cmd(1'b0, 32'h50, '0, '0, 3'b000, 1'b0, 32'h0);
        tick();
        #1;
        PRESETn = 1'b0;
        #1;
        exp_q.delete();
        compared++;
        if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_access: PSEL=%b PENABLE=%b rsp_valid=%b cmd_ready=%b want 0 0 0 0",
                     PSEL, PENABLE, rsp_valid, cmd_ready);
        end
        tick();
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        tick();
        compared++;
        if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
            mismatched++;
            $display("FAIL rst_release: cmd_ready=%b PSEL=%b rsp_valid=%b want 1 0 0", cmd_ready, PSEL, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
`ifdef APB_MST_TIMEOUT_EN
        send_cmd(1'b0, 32'h60, '0, '0, 3'b000, 1'b1, 32'h0);
        tick();
        for (int c = 0; c < TO; c++) begin
            compared++;
            if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
                mismatched++;
                $display("FAIL timeout_wait_%0d: PSEL=%b PENABLE=%b rsp_valid=%b want 1 1 0", c, PSEL, PENABLE, rsp_valid);
            end
            tick();
        end
        compared++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b001) begin
            mismatched++;
            $display("FAIL timeout_end: PSEL=%b PENABLE=%b rsp_valid=%b want 0 0 1", PSEL, PENABLE, rsp_valid);
        end
        collect_rsp("timeout", 1);
`else
        send_cmd(1'b0, 32'h60, '0, '0, 3'b000, 1'b0, 32'h600D_CAFE);
        tick();
        for (int c = 0; c < 100; c++) begin
            compared++;
            if ({PENABLE, rsp_valid} !== 2'b10) begin
                mismatched++;
                $display("FAIL stall_%0d: PENABLE=%b rsp_valid=%b want 1 0", c, PENABLE, rsp_valid);
            end
            tick();
        end
        PREADY = 1'b1;
        PRDATA = 32'h600D_CAFE;
        tick();
        collect_rsp("stall", 2);
`endif
        PREADY = 1'b1;
    endtask

    task automatic test_random();
        logic          wr;
        logic          err;
        logic [DW-1:0] rd;
        int            waits;
        for (int t = 0; t < 12; t++) begin
            wr    = 1'($urandom_range(0, 1));
            err   = 1'($urandom_range(0, 1));
            rd    = DW'($urandom());
            waits = $urandom_range(0, 3);
            send_cmd(wr, AW'($urandom()), DW'($urandom()), SW'($urandom()), 3'($urandom()), err, wr ? '0 : rd);
            compared++;
            if (PSTRB !== (wr ? cmd_strb : 4'h0) || PADDR !== cmd_addr || PWDATA !== cmd_wdata) begin
                mismatched++;
                $display("FAIL rand%0d_setup: PSTRB=%h PADDR=%h PWDATA=%h want %h %h %h",
                         t, PSTRB, PADDR, PWDATA, wr ? cmd_strb : 4'h0, cmd_addr, cmd_wdata);
            end
            tick();
            for (int w = 0; w <= waits; w++) begin
                PREADY  = (w == waits);
                PRDATA  = (w == waits) ? rd : ~rd;
                PSLVERR = (w == waits) ? err : ~err;
                tick();
            end
            collect_rsp($sformatf("rand%0d", t), 2);
        end
        PSLVERR = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_reset_access();
        test_timeout();
        test_random();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
